// File: rtl/regfile_arbiter.sv
// Round-robin arbitrated single-port 8x16 register file for two requesters.
// Optional REGFILE_ARB_R0_ZERO_EN hardwires register 0 to zero.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_idx,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_idx,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    // prio_q = 0 means m0 wins a tie
    logic              prio_q;
    logic              prio_d;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic              xfer;
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_val;
    logic              wr_en;
    logic              m0_rd;
    logic              m1_rd;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = ~prio_q;
                m1_gnt = prio_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign xfer   = m0_gnt | m1_gnt;
    assign sel    = m1_gnt;
    assign we     = sel ? m1_we    : m0_we;
    assign idx    = sel ? m1_idx   : m0_idx;
    assign wdata  = sel ? m1_wdata : m0_wdata;
    assign prio_d = xfer ? ~sel : prio_q;
    assign m0_rd  = m0_gnt & ~m0_we;
    assign m1_rd  = m1_gnt & ~m1_we;

`ifdef REGFILE_ARB_R0_ZERO_EN
    assign wr_en  = xfer & we & (idx != '0);
    assign rd_val = (idx == '0) ? '0 : regs_q[idx];
`else
    assign wr_en  = xfer & we;
    assign rd_val = regs_q[idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            prio_q      <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            m0_rvalid_q <= m0_rd;
            m1_rvalid_q <= m1_rd;
            if (m0_rd) begin
                m0_rdata_q <= rd_val;
            end
            if (m1_rd) begin
                m1_rdata_q <= rd_val;
            end
            if (wr_en) begin
                regs_q[idx] <= wdata;
            end
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Single-port, round-robin-arbitrated access controller for an 8-entry x 16-bit register file.
- Shares the one read/write port between two requesters (m0 = datapath/ALU side, m1 = load/debug side).
- Owns the register storage and returns read data with fixed one-cycle latency.
- Sits between the datapath sequencer and the register storage; every register access in the datapath goes through it.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; entry count = 2**ADDR_W (8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  requester 0 access request
m0_we  input  1  requester 0 write enable (1 = write, 0 = read)
m0_idx  input  ADDR_W  requester 0 register index
m0_wdata  input  DATA_W  requester 0 write data
m0_gnt  output  1  requester 0 grant (combinational)
m0_rvalid  output  1  requester 0 read data valid (registered)
m0_rdata  output  DATA_W  requester 0 read data (registered)
m1_req, m1_we, m1_idx, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the m0 ports, for requester 1

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - all 8 registers = 0
  - priority pointer = m0
  - m0_rvalid = m1_rvalid = 0
  - m0_rdata = m1_rdata = 0
  - gnt outputs are combinational and forced to 0 while rst = 1.
- Arbitration (combinational, each cycle):
  - only one req high -> that requester is granted.
  - both req high -> the requester holding priority is granted; the other gets gnt = 0.
  - neither req high -> no grant; pointer holds.
- Transfer: occurs at a rising edge where req & gnt = 1 for a requester. At most one transfer per cycle.
- Pointer update: after any transfer, priority moves to the other requester. With no transfer, the pointer holds.
- Requester rules:
  - hold req, we, idx and wdata stable until gnt is seen.
  - req may drop after the transfer edge.
  - back-to-back requests are allowed.
- Write transfer:
  - reg[idx] <= wdata at the transfer edge.
  - no rvalid is produced for a write.
- Read transfer:
  - at the transfer edge, the granted side's rdata <= reg[idx] and its rvalid <= 1.
  - latency is 1 cycle: data is valid the cycle after the grant cycle.
  - rvalid is a one-cycle pulse unless another read for the same side is granted in the next cycle.
- rdata holds its last value when rvalid = 0. The non-granted side's rvalid is 0.
- Write then read of the same index in consecutive cycles returns the new value (storage is updated before the read edge).
- Sustained contention: both requesters held high alternate m0, m1, m0, ... with no starvation; each waits at most one cycle.
- Index range: every value of idx is valid; there is no out-of-range case.
- Reset mid-operation: a read granted in the cycle rst is asserted produces no rvalid. Register contents are cleared regardless of in-flight writes.

Optional Feature:
- Macro: REGFILE_ARB_R0_ZERO_EN
- Defined:
  - register 0 is hardwired to 0.
  - writes to idx 0 are still granted (consume the slot, pointer still rotates) but the data is discarded.
  - reads of idx 0 return 0.
- Undefined: register 0 is a normal storage register.

Test Plan:
- Reset: assert rst for 2 cycles -> all gnt and rvalid 0, rdata 0. Then m0 reads idx 0..7 -> 0x0000 each, rvalid 1 cycle after each gnt.
- Single requester write/read: m0 writes 0xBEEF to idx 3, then reads idx 3 next cycle -> m0_rvalid = 1 with m0_rdata = 0xBEEF one cycle after the read grant; m1_rvalid stays 0.
- Contention: both req held high for 4 cycles from reset, reads of idx 1 (m0) and idx 2 (m1) preloaded with 0x1111 and 0x2222 -> grant order m0, m1, m0, m1. rdata 0x1111 and 0x2222 arrive on the respective sides, each one cycle after its grant.
- Stall/hold: m1 write of 0x5A5A to idx 7 requested while m0 holds priority and also requests -> m1_gnt = 0 for one cycle, then 1. The idx 7 readback is 0x5A5A, never a partial value.
- Reset mid-read: m0 read granted in the same cycle rst = 1 -> m0_rvalid stays 0 the next cycle, and a readback of the previously written idx 3 returns 0x0000.
- With REGFILE_ARB_R0_ZERO_EN: m0 writes 0xFFFF to idx 0, then reads idx 0 -> gnt given, rdata = 0x0000. Without the macro the same sequence returns 0xFFFF.
